// File: rtl/text_pkg.sv
// Shared constants and helpers for the 80x30 text-mode pixel generator.
// Contents: active-area geometry, glyph cell size, text grid size, address
// widths, and the glyph-row bit picker used by the colour stage.
package text_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned GLYPH_W  = 8;
    localparam int unsigned GLYPH_H  = 16;
    localparam int unsigned COLS     = 80;
    localparam int unsigned ROWS     = 30;
    localparam int unsigned TEXT_AW  = 12;
    localparam int unsigned ROM_AW   = 11;

    // Glyph rows are stored MSB-first: bit 7 is the leftmost pixel.
    function automatic logic glyph_bit(input logic [7:0] row, input logic [2:0] col);
        return row[3'd7 - col];
    endfunction

endpackage

// File: rtl/text_pixel_gen_if.sv
// Memory-side bus of the text pixel generator: character-buffer read port and
// font-ROM read port. Both memories are synchronous with 1-cycle read latency.
//   text_addr : generator -> buffer, {cell_row, cell_col}
//   text_data : buffer -> generator, 7-bit ASCII code
//   rom_addr  : generator -> ROM, {ascii, glyph_row}
//   rom_data  : ROM -> generator, glyph row, bit 7 leftmost
interface text_pixel_gen_if;
    import text_pkg::*;

    logic [TEXT_AW-1:0] text_addr;
    logic [6:0]         text_data;
    logic [ROM_AW-1:0]  rom_addr;
    logic [7:0]         rom_data;

    modport master (
        output text_addr,
        output rom_addr,
        input  text_data,
        input  rom_data
    );

    modport slave (
        input  text_addr,
        input  rom_addr,
        output text_data,
        output rom_data
    );

endinterface

// File: rtl/pipe_delay.sv
// Fixed-depth delay line with asynchronous active-low reset to RESET_VAL.
// Ports: clk, rst_n, din (WIDTH), dout (WIDTH, din delayed DEPTH cycles).
module pipe_delay #(
    parameter int unsigned          WIDTH     = 1,
    parameter int unsigned          DEPTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: turns sync-generator coordinates into a 12-bit
// colour using an external character buffer and font ROM, with a blinking
// block cursor. Fixed latency of 3 cycles from pixel inputs to rgb/syncs.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   pixel_x, pixel_y           current pixel coordinates
//   video_on                   active-area flag
//   hsync_in, vsync_in         active-low syncs from the sync generator
//   mem                        character buffer / font ROM bus (master side)
//   cursor_en/col/row          cursor enable and cell position
//   rgb, hsync_out, vsync_out  registered, latency-aligned outputs
module text_pixel_gen
    import text_pkg::*;
#(
    parameter logic [11:0]  FG_RGB       = 12'hFFF,
    parameter logic [11:0]  BG_RGB       = 12'h000,
    parameter int unsigned  BLINK_FRAMES = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [9:0]              pixel_x,
    input  logic [9:0]              pixel_y,
    input  logic                    video_on,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    text_pixel_gen_if.master        mem,
    input  logic                    cursor_en,
    input  logic [6:0]              cursor_col,
    input  logic [4:0]              cursor_row,
    output logic [11:0]             rgb,
    output logic                    hsync_out,
    output logic                    vsync_out
);

    localparam int unsigned CntW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BLINK_FRAMES - 1);

    // Off-screen rows rely on video_on for blanking, so pixel_y[9] is unused.
    logic unused_y9;
    assign unused_y9 = pixel_y[9];

    // Stage n: cell lookup and cursor compare.
    logic cursor_hit;
    assign mem.text_addr = {pixel_y[8:4], pixel_x[9:3]};
    assign cursor_hit    = (pixel_x[9:3] == cursor_col) && (pixel_y[8:4] == cursor_row)
                           && cursor_en;

    // Stage n+1: glyph row index follows the buffer's read latency.
    logic [3:0] row_d1;
    pipe_delay #(.WIDTH(4), .DEPTH(1), .RESET_VAL(4'h0)) u_row_d1 (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pixel_y[3:0]),
        .dout  (row_d1)
    );
    assign mem.rom_addr = {mem.text_data, row_d1};

    // Stage n+2: per-pixel attributes aligned with rom_data.
    logic [2:0] x_d2;
    logic       von_d2;
    logic       hit_d2;
    pipe_delay #(.WIDTH(5), .DEPTH(2), .RESET_VAL(5'b0)) u_pix_d2 (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({pixel_x[2:0], video_on, cursor_hit}),
        .dout  ({x_d2, von_d2, hit_d2})
    );

    // Syncs take the full 3 cycles; the last stage doubles as the output register.
    pipe_delay #(.WIDTH(2), .DEPTH(3), .RESET_VAL(2'b11)) u_sync_d3 (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({hsync_in, vsync_in}),
        .dout  ({hsync_out, vsync_out})
    );

    // Frame counter and blink phase, advanced on vsync falling edges.
    logic            vsync_q;
    logic [CntW-1:0] frame_cnt_q, frame_cnt_d;
    logic            blink_q, blink_d;
    logic            frame_tick;

    assign frame_tick = vsync_q & ~vsync_in;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (frame_tick) begin
            if (frame_cnt_q == CntLast) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Colour stage.
    logic        pix_bit;
    logic [11:0] rgb_d, rgb_q;

    always_comb begin
        pix_bit = glyph_bit(mem.rom_data, x_d2) ^ (hit_d2 & blink_q);
        rgb_d   = 12'h000;
        if (von_d2) begin
            rgb_d = pix_bit ? FG_RGB : BG_RGB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b1;
            frame_cnt_q <= '0;
            blink_q     <= 1'b1;
            rgb_q       <= 12'h000;
        end else begin
            vsync_q     <= vsync_in;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rgb = rgb_q;

endmodule

// File: doc/text_pixel_gen.md
TEXT_PIXEL_GEN -- requirements
Module: text_pixel_gen

Interface
REQ-001 Parameter FG_RGB, default 12'hFFF: foreground colour applied to glyph "1" bits.
REQ-002 Parameter BG_RGB, default 12'h000: background colour applied to glyph "0" bits.
REQ-003 Parameter BLINK_FRAMES, default 32: number of frames per cursor blink half-period.
REQ-004 Port list, one per line:
- clk  in  1  single system/pixel clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pixel_x  in  10  current pixel column from sync generator.
- pixel_y  in  10  current pixel row.
- video_on  in  1  high inside the 640x480 active area.
- hsync_in  in  1  horizontal sync, active-low.
- vsync_in  in  1  vertical sync, active-low.
- text_addr  out  12  character-buffer read address, {pixel_y[8:4], pixel_x[9:3]}.
- text_data  in  7  ASCII code; the buffer has a synchronous read with 1-cycle latency.
- rom_addr  out  11  font ROM address, {text_data, row[3:0]}; the ROM registers its address, giving 1-cycle latency.
- rom_data  in  8  glyph row; bit 7 is the leftmost pixel.
- cursor_en  in  1  cursor display enable.
- cursor_col  in  7  cursor cell column, 0..79.
- cursor_row  in  5  cursor cell row, 0..29.
- rgb  out  12  pixel colour, registered.
- hsync_out  out  1  hsync_in delayed to align with rgb, registered.
- vsync_out  out  1  vsync_in delayed to align with rgb, registered.

Function
REQ-005 text_addr SHALL be combinational from pixel_x and pixel_y in cycle n.
REQ-006 rom_addr SHALL be combinational in cycle n+1: text_data concatenated with pixel_y[3:0] delayed by 1 cycle.
REQ-007 rgb, hsync_out and vsync_out SHALL be valid in cycle n+3 for inputs presented in cycle n (fixed latency 3, no stalls).
REQ-008 pixel_x[2:0], pixel_y[3:0], video_on, the cursor-match flag, hsync_in and vsync_in SHALL be delayed through a pipeline so they align with rom_data in cycle n+2.
REQ-009 Glyph bit SHALL be rom_data[7 - x_d2[2:0]].
REQ-010 Cursor match SHALL be computed in cycle n: (pixel_x[9:3]==cursor_col) && (pixel_y[8:4]==cursor_row) && cursor_en.
REQ-011 When the aligned cursor match and blink_phase are both 1, the glyph bit SHALL be inverted before colour selection.
REQ-012 The registered rgb SHALL be:
- 12'h000 when aligned video_on=0;
- otherwise FG_RGB when the effective bit is 1;
- otherwise BG_RGB.
REQ-013 A frame tick SHALL be generated on each 1->0 transition of vsync_in, detected with a registered copy of vsync_in.
REQ-014 frame_cnt SHALL increment on each frame tick, counting 0..BLINK_FRAMES-1.
REQ-015 On a frame tick with frame_cnt==BLINK_FRAMES-1, frame_cnt SHALL wrap to 0 and blink_phase SHALL toggle.
REQ-016 A cursor_col/cursor_row change SHALL take effect on the next pixel presented; cells already in the pipeline are unaffected.
REQ-017 Pixels with pixel_x>=640 or pixel_y>=480 SHALL rely on video_on=0 for blanking; no separate range check SHALL be performed.

Reset
REQ-018 While rst_n=0, the following SHALL hold:
- rgb=12'h000, hsync_out=1, vsync_out=1;
- all pipeline video_on bits=0, pipeline sync bits=1;
- frame_cnt=0, blink_phase=1, vsync edge register=1.
REQ-019 Reset assertion mid-line SHALL clear the pipeline immediately.
REQ-020 After release, output SHALL be blank/inactive for 3 cycles, then follow inputs.

Structure
REQ-021 Shared package text_pkg SHALL hold:
- H_ACTIVE=640, V_ACTIVE=480;
- GLYPH_W=8, GLYPH_H=16;
- COLS=80, ROWS=30;
- TEXT_AW=12, ROM_AW=11.
REQ-022 One sub-module, pipe_delay (parameters WIDTH, DEPTH, RESET_VAL), SHALL implement all delay lines.

Verification
REQ-023 Steady pixels, video_on=1 at cycle 0 -> rgb first non-zero at cycle 3, never earlier.
REQ-024 Character cell (col 0, row 0) holds 8'h30 ('0'), ROM model returns 8'b01111100 at addr 11'h302 -> line y=2, x=0..7 yields BG,FG,FG,FG,FG,FG,BG,BG.
REQ-025 Cursor at (5,3), cursor_en=1, blink_phase=1, cell holds 8'h00 -> pixels x=40..47, y=48..63 are all FG_RGB; with cursor_en=0 they are BG_RGB.
REQ-026 BLINK_FRAMES=2, 5 vsync falling edges from reset -> blink_phase sequence 1,1,0,0,1,1 (toggles after edges 2 and 4).
REQ-027 video_on=0 with rom_data=8'hFF -> rgb=12'h000; hsync_in pulse at cycle 10 appears on hsync_out at cycle 13.
REQ-028 rst_n asserted mid-line, then released -> rgb=0 and syncs=1 immediately, and they remain so for 3 cycles after release.
